// File: rtl/hdmi_to_blocks.sv
// Raster-to-block converter: HDMI capture lines into two 8-line banks,
// read out as 8x8 blocks in 64/N-beat bursts.
module hdmi_to_blocks #(
   parameter int N     = 2,
   parameter int X_RES = 2160,
   parameter int Y_RES = 1200
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hdmi_v_sync,
   input  logic                    hdmi_h_sync,
   input  logic                    hdmi_data_valid,
   input  logic signed [N-1:0][7:0] hdmi_data_y,
   input  logic signed [N-1:0][7:0] hdmi_data_cr,
   input  logic signed [N-1:0][7:0] hdmi_data_cb,
   output logic                    blk_valid,
   output logic signed [N-1:0][7:0] blk_data_y,
   output logic signed [N-1:0][7:0] blk_data_cr,
   output logic signed [N-1:0][7:0] blk_data_cb,
   output logic                    blk_sob,
   output logic                    blk_eob,
   output logic                    blk_sof,
   output logic                    ovf
);
   localparam int W     = X_RES / N;
   localparam int NB    = X_RES / 8;
   localparam int BPR   = 8 / N;
   localparam int BEATS = 64 / N;
   localparam int CW    = (W > 1) ? $clog2(W) : 1;
   localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int KW    = $clog2(BEATS);
   localparam int LW    = (Y_RES > 1) ? $clog2(Y_RES) : 1;
   localparam int AW    = $clog2(16 * W);
   localparam int SH    = $clog2(BPR);
   localparam int DW    = 3 * N * 8;

   typedef enum logic [1:0] {EMPTY, FULL, READING} bank_t;
   typedef enum logic {IDLE, BURST} rd_t;

   logic          vs_d, hs_d, done, wr_bank, sof_pend;
   logic [CW-1:0] col;
   logic [2:0]    row;
   logic [LW-1:0] line;
   bank_t         st [2];
   logic [1:0]    sof_bank;

   logic vs_rise, hs_rise, accept, hs_wrap, row_adv, fill, wr_clash;

   rd_t           state, nxt;
   logic [KW-1:0] k, kcol;
   logic [BW-1:0] b;
   logic [2:0]    rrow;
   logic          rd_bank, rd_en, rel, start, start_bank, last_beat;

   logic [AW-1:0] wa, ra;
   logic [DW-1:0] mem [16*W];
   logic [DW-1:0] rdata;
   logic          p1_valid, p1_sob, p1_eob, p1_sof;

   assign vs_rise  = hdmi_v_sync & ~vs_d;
   assign hs_rise  = hdmi_h_sync & ~hs_d;
   assign accept   = hdmi_data_valid & ~done & ~vs_rise & ~hs_rise;
   assign hs_wrap  = hs_rise & ~vs_rise & ~done & (col != '0);
   assign row_adv  = hs_wrap | (accept & (col == CW'(W - 1)));
   assign fill     = row_adv & (row == 3'd7);
   // a bank released in this very cycle is free to take the write
   assign wr_clash = (st[wr_bank] != EMPTY) &
                     ~(rel & (rd_bank == wr_bank));

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d     <= 1'b0;
         hs_d     <= 1'b0;
         col      <= '0;
         row      <= '0;
         line     <= '0;
         done     <= 1'b0;
         wr_bank  <= 1'b0;
         sof_pend <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         vs_d <= hdmi_v_sync;
         hs_d <= hdmi_h_sync;
         if (accept & wr_clash) ovf <= 1'b1;
         if (vs_rise) begin
            col      <= '0;
            row      <= '0;
            line     <= '0;
            done     <= 1'b0;
            sof_pend <= 1'b1;
         end else begin
            if (row_adv) col <= '0;
            else if (accept) col <= col + CW'(1);
            if (row_adv) begin
               row <= row + 3'd1;
               if (line == LW'(Y_RES - 1)) done <= 1'b1;
               else line <= line + LW'(1);
            end
            if (fill) begin
               wr_bank  <= ~wr_bank;
               sof_pend <= 1'b0;
            end
         end
      end
   end

   // release first, then READING, then FULL: later writes win
   always_ff @(posedge clk) begin
      if (rst) begin
         st[0]    <= EMPTY;
         st[1]    <= EMPTY;
         sof_bank <= '0;
      end else begin
         if (rel) st[rd_bank] <= EMPTY;
         if (start) st[start_bank] <= READING;
         if (fill) begin
            st[wr_bank]       <= FULL;
            sof_bank[wr_bank] <= sof_pend;
         end
      end
   end

   assign last_beat = (state == BURST) & (k == KW'(BEATS - 1)) &
                      (b == BW'(NB - 1));

   always_comb begin
      nxt        = state;
      rd_en      = 1'b0;
      rel        = 1'b0;
      start      = 1'b0;
      start_bank = rd_bank;
      unique case (state)
         IDLE: begin
            if (st[rd_bank] == FULL) begin
               rd_en = 1'b1;
               start = 1'b1;
               nxt   = BURST;
            end
         end
         BURST: begin
            rd_en = 1'b1;
            if (last_beat) begin
               rel = 1'b1;
               if (st[~rd_bank] == FULL) begin
                  start      = 1'b1;
                  start_bank = ~rd_bank;
               end else begin
                  nxt = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         b       <= '0;
         rd_bank <= 1'b0;
      end else begin
         state <= nxt;
         if (rd_en) begin
            if (k == KW'(BEATS - 1)) begin
               k <= '0;
               b <= (b == BW'(NB - 1)) ? '0 : b + BW'(1);
            end else begin
               k <= k + KW'(1);
            end
         end
         if (rel) rd_bank <= ~rd_bank;
      end
   end

   assign kcol = k & KW'(BPR - 1);
   assign rrow = 3'(k >> SH);
   assign wa   = AW'({wr_bank, row}) * AW'(W) + AW'(col);
   assign ra   = AW'({rd_bank, rrow}) * AW'(W) +
                 AW'(b) * AW'(BPR) + AW'(kcol);

   always_ff @(posedge clk) begin
      if (accept) mem[wa] <= {hdmi_data_y, hdmi_data_cr, hdmi_data_cb};
      if (rd_en) rdata <= mem[ra];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_valid    <= 1'b0;
         p1_sob      <= 1'b0;
         p1_eob      <= 1'b0;
         p1_sof      <= 1'b0;
         blk_valid   <= 1'b0;
         blk_sob     <= 1'b0;
         blk_eob     <= 1'b0;
         blk_sof     <= 1'b0;
         blk_data_y  <= '0;
         blk_data_cr <= '0;
         blk_data_cb <= '0;
      end else begin
         p1_valid    <= rd_en;
         p1_sob      <= rd_en & (k == '0);
         p1_eob      <= rd_en & (k == KW'(BEATS - 1));
         p1_sof      <= rd_en & (k == '0) & (b == '0) & sof_bank[rd_bank];
         blk_valid   <= p1_valid;
         blk_sob     <= p1_sob;
         blk_eob     <= p1_eob;
         blk_sof     <= p1_sof;
         blk_data_y  <= rdata[DW-1 -: N*8];
         blk_data_cr <= rdata[2*N*8-1 -: N*8];
         blk_data_cb <= rdata[N*8-1:0];
      end
   end
endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Directed bench for hdmi_to_blocks: 16x16 frames, N=2, checked
// against a pixel-formula model of the block readout order.
module tb_hdmi_to_blocks;
   localparam int N  = 2;
   localparam int XR = 16;
   localparam int YR = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vs = 1'b0, hs = 1'b0, dv = 1'b0;
   logic signed [N-1:0][7:0] hy = '0, hcr = '0, hcb = '0;
   logic blk_valid, blk_sob, blk_eob, blk_sof, ovf;
   logic signed [N-1:0][7:0] by, bcr, bcb;

   hdmi_to_blocks #(.N(N), .X_RES(XR), .Y_RES(YR)) dut (
      .clk(clk), .rst(rst),
      .hdmi_v_sync(vs), .hdmi_h_sync(hs), .hdmi_data_valid(dv),
      .hdmi_data_y(hy), .hdmi_data_cr(hcr), .hdmi_data_cb(hcb),
      .blk_valid(blk_valid),
      .blk_data_y(by), .blk_data_cr(bcr), .blk_data_cb(bcb),
      .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] cy[$], ccr[$], ccb[$];
   logic [2:0]  cf[$];
   int          cc[$];

   always begin
      @(posedge clk);
      #1;
      if (blk_valid === 1'b1) begin
         cy.push_back(by);
         ccr.push_back(bcr);
         ccb.push_back(bcb);
         cf.push_back({blk_sof, blk_sob, blk_eob});
         cc.push_back(cyc);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int t7 = 0;
   bit abort = 1'b0;

   function automatic logic [7:0] pix(int l, int x, int off);
      return 8'((l * 16 + x + off) % 128);
   endfunction

   // block bb: bank bb/2, block bb%2; beat k: row k/4, pixel pair k%4
   function automatic logic [15:0] ey(int bb, int k, int off);
      int l, x;
      l = (bb / 2) * 8 + k / 4;
      x = (bb % 2) * 8 + (k % 4) * 2;
      return {pix(l, x + 1, off), pix(l, x, off)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      cy.delete(); ccr.delete(); ccb.delete(); cf.delete(); cc.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; dv = 1'b0; vs = 1'b0; hs = 1'b0; abort = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      clear_caps();
   endtask

   task automatic send_line(int l, int nb, int blank, int off);
      for (int i = 0; i < nb; i++) begin
         if (abort) break;
         dv  = 1'b1;
         hy  = {pix(l, 2*i + 1, off), pix(l, 2*i, off)};
         hcr = ~hy;
         hcb = hy ^ 16'h5a5a;
         if (l == 7 && i == nb - 1) t7 = cyc + 1;
         tick();
      end
      dv = 1'b0;
      for (int i = 0; i < blank; i++) begin
         if (abort) break;
         hs = (i == 2);
         tick();
      end
      hs = 1'b0;
   endtask

   task automatic send_frame(int off, int short_l);
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
      for (int l = 0; l < YR; l++) begin
         if (abort) break;
         send_line(l, (l == short_l) ? 6 : 8, 10, off);
      end
      dv = 1'b0;
   endtask

   task automatic wait_caps(int n, int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (cy.size() >= n) break;
         tick();
      end
      repeat (4) tick();
      ok = (cy.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (blk_valid !== 1'b0 || blk_sob !== 1'b0 || blk_eob !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctl: valid/sob/eob=%b%b%b want 000",
                  blk_valid, blk_sob, blk_eob);
      end
      n_cmp++;
      if (blk_sof !== 1'b0 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags: sof/ovf=%b%b want 00", blk_sof, ovf);
      end
      n_cmp++;
      if (by !== 16'h0 || bcr !== 16'h0 || bcb !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_data: y/cr/cb=%h/%h/%h want 0", by, bcr, bcb);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_frame();
      bit ok;
      logic [15:0] e;
      logic [2:0] ef;
      do_reset();
      send_frame(0, -1);
      wait_caps(128, 300, ok);
      n_cmp++;
      if (!ok || cy.size() != 128) begin
         n_bad++;
         $display("FAIL frame_count: got %0d beats want 128", cy.size());
      end
      if (cy.size() >= 32) begin
         n_cmp++;
         if (cy[0] !== 16'h0100) begin
            n_bad++;
            $display("FAIL frame_b0: y=%h want 0100", cy[0]);
         end
         n_cmp++;
         if (cy[4] !== 16'h1110) begin
            n_bad++;
            $display("FAIL frame_b4: y=%h want 1110", cy[4]);
         end
         n_cmp++;
         if (cy[31] !== 16'h7776) begin
            n_bad++;
            $display("FAIL frame_b31: y=%h want 7776", cy[31]);
         end
      end
      for (int i = 0; i < cy.size() && i < 128; i++) begin
         e  = ey(i / 32, i % 32, 0);
         ef = {i == 0, (i % 32) == 0, (i % 32) == 31};
         n_cmp++;
         if (cy[i] !== e || ccr[i] !== ~e || ccb[i] !== (e ^ 16'h5a5a)) begin
            n_bad++;
            $display("FAIL frame_data[%0d]: y/cr/cb=%h/%h/%h want %h/%h/%h",
                     i, cy[i], ccr[i], ccb[i], e, ~e, e ^ 16'h5a5a);
         end
         n_cmp++;
         if (cf[i] !== ef) begin
            n_bad++;
            $display("FAIL frame_flags[%0d]: sof/sob/eob=%b want %b",
                     i, cf[i], ef);
         end
      end
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL frame_ovf: ovf=%b want 0", ovf);
      end
   endtask

   task automatic test_latency();
      bit ok;
      do_reset();
      send_frame(0, -1);
      wait_caps(128, 300, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL lat_timeout: got %0d beats want 128", cy.size());
      end
      if (cc.size() >= 65) begin
         n_cmp++;
         if (cc[0] != t7 + 2) begin
            n_bad++;
            $display("FAIL lat_first: cycle %0d want %0d", cc[0], t7 + 2);
         end
         n_cmp++;
         if (cc[63] != cc[0] + 63) begin
            n_bad++;
            $display("FAIL lat_run: beat63 cycle %0d want %0d",
                     cc[63], cc[0] + 63);
         end
         n_cmp++;
         if (cc[64] <= cc[63] + 1) begin
            n_bad++;
            $display("FAIL lat_gap: beat64 cycle %0d want > %0d",
                     cc[64], cc[63] + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [15:0] e;
      logic sf;
      do_reset();
      send_frame(0, -1);
      send_frame(64, -1);
      wait_caps(256, 300, ok);
      n_cmp++;
      if (!ok || cy.size() != 256) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d beats want 256", cy.size());
      end
      if (cy.size() >= 129) begin
         n_cmp++;
         if (cy[128] !== 16'h4140) begin
            n_bad++;
            $display("FAIL b2b_first: y=%h want 4140", cy[128]);
         end
      end
      for (int i = 0; i < cy.size() && i < 256; i++) begin
         e  = ey((i % 128) / 32, i % 32, (i >= 128) ? 64 : 0);
         sf = (i == 0 || i == 128);
         n_cmp++;
         if (cy[i] !== e || cf[i][2] !== sf) begin
            n_bad++;
            $display("FAIL b2b[%0d]: y=%h sof=%b want %h sof=%b",
                     i, cy[i], cf[i][2], e, sf);
         end
      end
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_ovf: ovf=%b want 0", ovf);
      end
   endtask

   task automatic test_short_line();
      bit ok;
      logic [15:0] e;
      int k;
      do_reset();
      send_frame(0, 3);
      wait_caps(128, 300, ok);
      n_cmp++;
      if (!ok || cy.size() != 128) begin
         n_bad++;
         $display("FAIL short_count: got %0d beats want 128", cy.size());
      end
      for (int i = 0; i < cy.size() && i < 128; i++) begin
         k = i % 32;
         if (!((i / 32) == 1 && (k == 14 || k == 15))) begin
            e = ey(i / 32, k, 0);
            n_cmp++;
            if (cy[i] !== e) begin
               n_bad++;
               $display("FAIL short[%0d]: y=%h want %h", i, cy[i], e);
            end
         end
      end
   endtask

   task automatic one_row(int r);
      dv = 1'b1;
      hy = 16'(r);
      tick();
      dv = 1'b0;
      hs = 1'b1;
      tick();
      hs = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
      for (int r = 0; r < 16; r++) one_row(r);
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_two_fills: ovf=%b want 0", ovf);
      end
      for (int r = 0; r < 8; r++) one_row(r);
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_dropped: ovf=%b want 0", ovf);
      end
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
      for (int r = 0; r < 8; r++) one_row(r);
      tick();
      n_cmp++;
      if (ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_third: ovf=%b want 1", ovf);
      end
      repeat (200) tick();
      n_cmp++;
      if (ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_sticky: ovf=%b want 1", ovf);
      end
      do_reset();
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear: ovf=%b want 0", ovf);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit got, ok;
      int held;
      logic [15:0] e;
      logic [2:0] ef;
      do_reset();
      got = 1'b0;
      fork
         send_frame(0, -1);
         begin
            for (int i = 0; i < 600 && !got; i++) begin
               @(posedge clk);
               #2;
               if (cy.size() >= 11) got = 1'b1;
            end
            if (got) begin
               rst = 1'b1;
               abort = 1'b1;
               @(posedge clk);
               #2;
               n_cmp++;
               if (blk_valid !== 1'b0) begin
                  n_bad++;
                  $display("FAIL rstb_valid: valid=%b want 0", blk_valid);
               end
               rst = 1'b0;
            end
         end
      join
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL rstb_timeout: got %0d beats want 11", cy.size());
      end
      dv = 1'b0;
      held = cy.size();
      repeat (100) tick();
      n_cmp++;
      if (cy.size() != held) begin
         n_bad++;
         $display("FAIL rstb_quiet: got %0d beats want %0d", cy.size(), held);
      end
      abort = 1'b0;
      clear_caps();
      send_frame(0, -1);
      wait_caps(128, 300, ok);
      n_cmp++;
      if (!ok || cy.size() != 128) begin
         n_bad++;
         $display("FAIL rstb_count: got %0d beats want 128", cy.size());
      end
      for (int i = 0; i < cy.size() && i < 128; i++) begin
         e  = ey(i / 32, i % 32, 0);
         ef = {i == 0, (i % 32) == 0, (i % 32) == 31};
         n_cmp++;
         if (cy[i] !== e || cf[i] !== ef) begin
            n_bad++;
            $display("FAIL rstb_frame[%0d]: y=%h flags=%b want %h %b",
                     i, cy[i], cf[i], e, ef);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_latency();
      test_back_to_back();
      test_short_line();
      test_overflow();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
